// File: rtl/div_issue_ctrl.sv
// Issue/stall controller for RV32M DIV/DIVU/REM/REMU in front of a multi-cycle divider.
// Optional one-entry result reuse cache is enabled by defining DIV_REUSE_EN.
module div_issue_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    input  logic [2:0]            ex_funct3,
    input  logic [DATA_WIDTH-1:0] ex_rs1,
    input  logic [DATA_WIDTH-1:0] ex_rs2,
    input  logic [RD_WIDTH-1:0]   ex_rd,
    input  logic                  flush,
    output logic                  stall,
    output logic                  res_valid,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic [RD_WIDTH-1:0]   res_rd,
    output logic                  div_start,
    output logic [DATA_WIDTH-1:0] div_dividend,
    output logic [DATA_WIDTH-1:0] div_divisor,
    output logic                  div_signed,
    input  logic [DATA_WIDTH-1:0] div_quotient,
    input  logic [DATA_WIDTH-1:0] div_remainder,
    input  logic                  div_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] rs1_q, rs1_d;
    logic [DATA_WIDTH-1:0] rs2_q, rs2_d;
    logic [RD_WIDTH-1:0]   rd_q, rd_d;
    logic                  rem_sel_q, rem_sel_d;
    logic                  uns_q, uns_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;

    logic req;
    logic zero_div;
    logic ovf;
    logic hit;

    assign req      = ex_valid & ex_funct3[2] & ~flush;
    assign zero_div = (ex_rs2 == '0);
    assign ovf      = ~ex_funct3[0] & (ex_rs1 == MIN_NEG) & (ex_rs2 == '1);

`ifdef DIV_REUSE_EN
    logic [DATA_WIDTH-1:0] c_rs1_q, c_rs2_q, c_quo_q, c_rem_q;
    logic                  c_sgn_q, c_vld_q;
    logic                  c_fill;

    assign c_fill = (state_q == S_WAIT) & div_ready & ~flush;
    assign hit    = c_vld_q & (ex_rs1 == c_rs1_q) & (ex_rs2 == c_rs2_q)
                  & (c_sgn_q == ~ex_funct3[0]);

    // Cache entry survives flush; only a completed divider result overwrites it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_rs1_q <= '0;
            c_rs2_q <= '0;
            c_quo_q <= '0;
            c_rem_q <= '0;
            c_sgn_q <= 1'b0;
            c_vld_q <= 1'b0;
        end else if (c_fill) begin
            c_rs1_q <= rs1_q;
            c_rs2_q <= rs2_q;
            c_quo_q <= div_quotient;
            c_rem_q <= div_remainder;
            c_sgn_q <= ~uns_q;
            c_vld_q <= 1'b1;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            rem_sel_q <= 1'b0;
            uns_q     <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
        end else begin
            state_q   <= state_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            rem_sel_q <= rem_sel_d;
            uns_q     <= uns_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        rem_sel_d = rem_sel_q;
        uns_d     = uns_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        stall     = 1'b0;
        res_valid = 1'b0;
        div_start = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    stall     = 1'b1;
                    rs1_d     = ex_rs1;
                    rs2_d     = ex_rs2;
                    rd_d      = ex_rd;
                    rem_sel_d = ex_funct3[1];
                    uns_d     = ex_funct3[0];
                    // Corner cases and cache hits complete without the divider.
                    if (zero_div) begin
                        quo_d   = '1;
                        rem_d   = ex_rs1;
                        state_d = S_DONE;
                    end else if (ovf) begin
                        quo_d   = MIN_NEG;
                        rem_d   = '0;
                        state_d = S_DONE;
                    end else if (hit) begin
`ifdef DIV_REUSE_EN
                        quo_d   = c_quo_q;
                        rem_d   = c_rem_q;
`endif
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                stall     = 1'b1;
                div_start = 1'b1;
                state_d   = flush ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                stall = 1'b1;
                if (div_ready) begin
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        quo_d   = div_quotient;
                        rem_d   = div_remainder;
                        state_d = S_DONE;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                stall = 1'b1;
                if (div_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                res_valid = ~flush;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign res_data     = (state_q == S_DONE) ? (rem_sel_q ? rem_q : quo_q) : '0;
    assign res_rd       = (state_q == S_DONE) ? rd_q : '0;
    assign div_dividend = rs1_q;
    assign div_divisor  = rs2_q;
    assign div_signed   = ~uns_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl with a behavioural 32-cycle divider and
// an operation-level reference model (RISC-V division rules plus optional reuse cache).
module tb_div_issue_ctrl;

    localparam int unsigned DIV_LAT = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_rs1, ex_rs2;
    logic [4:0]  ex_rd;
    logic        flush;
    logic        stall, res_valid, div_start, div_signed;
    logic [31:0] res_data, div_dividend, div_divisor;
    logic [4:0]  res_rd;
    logic [31:0] div_quotient, div_remainder;
    logic        div_ready;

    int errors = 0;
    int checks = 0;

    // Reference model's view of the reuse cache.
    bit          m_cv;
    logic [31:0] m_ca, m_cb;
    bit          m_cs;

    always #5 clk = ~clk;

    div_issue_ctrl #(.DATA_WIDTH(32), .RD_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_funct3(ex_funct3),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .flush(flush),
        .stall(stall), .res_valid(res_valid), .res_data(res_data), .res_rd(res_rd),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_signed(div_signed), .div_quotient(div_quotient),
        .div_remainder(div_remainder), .div_ready(div_ready)
    );

    // RISC-V division semantics: {quotient, remainder}.
    function automatic logic [63:0] ref_qr(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] qr;
        qr = ref_qr(!f3[0], a, b);
        return f3[1] ? qr[31:0] : qr[63:32];
    endfunction

    // Behavioural divider: ready drops at the start edge, returns DIV_LAT edges later.
    int unsigned cnt_m;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_ready     <= 1'b1;
            cnt_m         <= 0;
            div_quotient  <= '0;
            div_remainder <= '0;
        end else if (div_start && div_ready) begin
            div_ready <= 1'b0;
            cnt_m     <= DIV_LAT;
            {div_quotient, div_remainder} <= ref_qr(div_signed, div_dividend, div_divisor);
        end else if (!div_ready) begin
            if (cnt_m == 1) div_ready <= 1'b1;
            cnt_m <= cnt_m - 1;
        end
    end

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction

    function automatic bit model_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bit fast;
        fast = (b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef DIV_REUSE_EN
        fast = fast || (m_cv && m_ca == a && m_cb == b && m_cs == !f3[0]);
`endif
        return fast;
    endfunction

    // Presents one instruction and holds it until the pipeline advances (stall low).
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp_data,
                          input bit chk_lat, input string tag);
        int n_stall = 0, n_start = 0, n_valid = 0, vcyc = 0, cyc = 0;
        logic [31:0] got_d = '0;
        logic [4:0]  got_rd = '0;
        logic        stall_at_v = 1'b0;
        bit done = 0;
        bit acc, fast;
        acc  = f3[2];
        fast = model_fast(f3, a, b);
        ex_valid = 1'b1; ex_funct3 = f3; ex_rs1 = a; ex_rs2 = b; ex_rd = rd;
        while (!done && cyc < 100) begin
            @(negedge clk);
            if (stall) n_stall++;
            if (div_start) n_start++;
            if (res_valid) begin
                n_valid++; got_d = res_data; got_rd = res_rd; vcyc = cyc; stall_at_v = stall;
            end
            if (!stall) done = 1;
            @(posedge clk); #1;
            cyc++;
        end
        ex_valid = 1'b0;
        check({tag, " retire"}, 32'(done), 32'd1);
        check({tag, " valid_cnt"}, 32'(n_valid), acc ? 32'd1 : 32'd0);
        check({tag, " start_cnt"}, 32'(n_start), (acc && !fast) ? 32'd1 : 32'd0);
        if (acc) begin
            check({tag, " data"}, got_d, exp_data);
            check({tag, " rd"}, 32'(got_rd), 32'(rd));
            check({tag, " stall_at_valid"}, 32'(stall_at_v), 32'd0);
            if (fast) check({tag, " fast_stall"}, 32'(n_stall), 32'd1);
            if (chk_lat) check({tag, " latency_ok"}, 32'(vcyc <= 36), 32'd1);
            if (!fast) begin
                m_cv = 1; m_ca = a; m_cb = b; m_cs = !f3[0];
            end
        end
    endtask

    task automatic wait_start(input string tag);
        bit found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (div_start) found = 1;
            @(posedge clk); #1;
        end
        check({tag, " issued"}, 32'(found), 32'd1);
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[12];

    initial begin
        bit found;
        logic [2:0]  f3;
        logic [31:0] a, b, pa, pb;
        int sel;

        tbl[0]  = '{3'b101, 32'd100,        32'd7,          5'd1,  32'd14};
        tbl[1]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,          5'd2,  32'hFFFF_FFFF};
        tbl[2]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFD};
        tbl[3]  = '{3'b100, 32'd5,          32'd0,          5'd4,  32'hFFFF_FFFF};
        tbl[4]  = '{3'b111, 32'd5,          32'd0,          5'd5,  32'd5};
        tbl[5]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd6,  32'h8000_0000};
        tbl[6]  = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd7,  32'd0};
        tbl[7]  = '{3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  5'd8,  32'd0};
        tbl[8]  = '{3'b100, 32'd100,        32'd7,          5'd9,  32'd14};
        tbl[9]  = '{3'b110, 32'd100,        32'd7,          5'd10, 32'd2};
        tbl[10] = '{3'b011, 32'd9,          32'd3,          5'd11, 32'd0};
        tbl[11] = '{3'b111, 32'hFFFF_FFFF,  32'd10,         5'd12, 32'd5};

        m_cv = 0; m_ca = '0; m_cb = '0; m_cs = 0;
        rst_n = 1'b0; ex_valid = 1'b0; ex_funct3 = '0; ex_rs1 = '0; ex_rs2 = '0;
        ex_rd = '0; flush = 1'b0;

        @(negedge clk);
        check("rst stall", 32'(stall), 32'd0);
        check("rst res_valid", 32'(res_valid), 32'd0);
        check("rst res_data", res_data, 32'd0);
        check("rst res_rd", 32'(res_rd), 32'd0);
        check("rst div_start", 32'(div_start), 32'd0);
        check("rst dividend", div_dividend, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) run_op(tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp, 1, $sformatf("vec%0d", i));

        // Flush in IDLE blocks acceptance.
        ex_valid = 1'b1; ex_funct3 = 3'b101; ex_rs1 = 32'd8; ex_rs2 = 32'd2; flush = 1'b1;
        @(negedge clk);
        check("flushIdle stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        ex_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flushIdle no_issue", 32'(stall | div_start), 32'd0);
        @(posedge clk); #1;

        // Flush in DONE suppresses the writeback pulse.
        ex_valid = 1'b1; ex_funct3 = 3'b100; ex_rs1 = 32'd5; ex_rs2 = 32'd0; ex_rd = 5'd20;
        @(negedge clk);
        check("flushDone accept_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        flush = 1'b1; ex_valid = 1'b0;
        @(negedge clk);
        check("flushDone res_valid", 32'(res_valid), 32'd0);
        check("flushDone stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;

        // Flush 5 cycles after issue, then a new op must wait out the drain.
        ex_valid = 1'b1; ex_funct3 = 3'b101; ex_rs1 = 32'd100; ex_rs2 = 32'd7; ex_rd = 5'd21;
        wait_start("flushWait");
        repeat (4) begin @(posedge clk); #1; end
        flush = 1'b1; ex_valid = 1'b0;
        @(negedge clk);
        check("flushWait res_valid", 32'(res_valid), 32'd0);
        check("flushWait stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        run_op(3'b101, 32'd9, 32'd3, 5'd22, 32'd3, 0, "afterDrain");

        // Flush coinciding with div_ready in WAIT returns straight to IDLE.
        ex_valid = 1'b1; ex_funct3 = 3'b101; ex_rs1 = 32'd50; ex_rs2 = 32'd5; ex_rd = 5'd23;
        wait_start("flushRdy");
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (div_ready) found = 1;
            else begin @(posedge clk); #1; end
        end
        check("flushRdy ready_seen", 32'(found), 32'd1);
        flush = 1'b1; ex_valid = 1'b0;
        #1;
        check("flushRdy res_valid", 32'(res_valid), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flushRdy idle_stall", 32'(stall), 32'd0);
        check("flushRdy idle_valid", 32'(res_valid), 32'd0);
        @(posedge clk); #1;

        // Reset mid-operation; the cache entry from the previous op must be gone afterwards.
        run_op(3'b100, 32'd100, 32'd7, 5'd24, 32'd14, 1, "preRst");
        ex_valid = 1'b1; ex_funct3 = 3'b100; ex_rs1 = 32'd100; ex_rs2 = 32'd7; ex_rd = 5'd25;
        repeat (10) begin @(posedge clk); #1; end
        ex_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midRst stall", 32'(stall), 32'd0);
        check("midRst res_valid", 32'(res_valid), 32'd0);
        check("midRst res_data", res_data, 32'd0);
        check("midRst dividend", div_dividend, 32'd0);
        m_cv = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(3'b110, 32'd100, 32'd7, 5'd26, 32'd2, 1, "postRst");

        // Randomized operations against the reference model.
        pa = 32'd1; pb = 32'd1;
        for (int i = 0; i < 150; i++) begin
            f3  = ($urandom_range(0, 9) >= 8) ? 3'($urandom_range(0, 3)) : 3'(4 + $urandom_range(0, 3));
            sel = $urandom_range(0, 9);
            case (sel)
                0: begin a = $urandom; b = 32'd0; end
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = pa; b = pb; end
                3: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
                default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
            endcase
            run_op(f3, a, b, 5'($urandom), ref_result(f3, a, b), 1, $sformatf("rnd%0d", i));
            pa = a; pb = b;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
